if_id_hazard_ctrl: RTL and testbench
====================================

Name: if_id_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V integer pipeline.
- Drives write-enable and flush for the PC, IF/ID, ID/EX and EX/MEM registers.
- Detects load-use hazards, taken branches/jumps resolved in EX, and data-memory wait states.
- Escalates a stuck memory access to a sticky timeout halt.

Parameters:
REG_ADDR_W, 5, architectural register index width
CNT_W, 32, width of performance counters (saturating)
MAX_MEM_WAIT, 15, consecutive memory-wait cycles tolerated before timeout halt

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high
id_rs1  in  REG_ADDR_W  source reg 1 of instruction in ID
id_rs2  in  REG_ADDR_W  source reg 2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_rd  in  REG_ADDR_W  destination reg of EX instruction
ex_branch_taken  in  1  EX resolved a taken branch/jump (PC redirect)
mem_req  in  1  MEM stage has an active data access
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to NOP (overrides write)
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear to bubble (overrides write)
ex_mem_write  out  1  EX/MEM load enable
mem_timeout  out  1  sticky: memory wait exceeded MAX_MEM_WAIT
stall_cycles  out  CNT_W  cycles with pc_write=0
flush_count  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Clock/reset: clk, reset synchronous active-high. Already decided.
- Control outputs are combinational from the current state and inputs; the pipeline registers sample them at the next edge. Counters, timeout flag and state are registered.
- Reset:
  - While reset=1: all *_write=0, both flushes=1.
  - Registered values after reset: state RUN, wait counter 0, mem_timeout=0, stall_cycles=0, flush_count=0.
  - Reset in any state, including MEM_WAIT and HALT, returns to RUN.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- mem_wait = mem_req & ~mem_ready.
- Priority in RUN and MEM_WAIT, one case per cycle:
  1. mem_wait: freeze everything. All *_write=0, no flushes.
  2. ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_write=1.
  3. load_use: pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1 (exactly 1 bubble).
  4. Otherwise: all *_write=1, no flushes.
- Branch and load_use in the same cycle: branch wins. The flush removes the dependent instruction.
- Branch while frozen: EX is held, so ex_branch_taken stays asserted. The flush applies in the release cycle (mem_ready=1).
- FSM states:
  - RUN: mem_wait -> MEM_WAIT, wait counter := 1.
  - MEM_WAIT:
    - mem_ready=1 -> RUN. The release cycle evaluates priority as in RUN, minus case 1.
    - Else if wait counter == MAX_MEM_WAIT -> HALT.
    - Else wait counter +1.
  - HALT: all *_write=0, no flushes, mem_timeout=1. Leaves only on reset.
- Load-use lasts 1 cycle: after the bubble, EX holds a NOP and the condition clears naturally.
- x0 (ex_rd=0) never causes a stall.
- Counters saturate at all-ones; no wrap.

Optional Feature:
HAZARD_PERF_CNT_EN.
- Defined: stall_cycles and flush_count are implemented as specified.
- Undefined: both ports are tied to 0 and no counter flops exist. Control behaviour is identical.

Decomposition:
- Package riscv_pipe_pkg holds:
  - REG_ADDR_W
  - X0 constant
  - hazard FSM state enum {RUN, MEM_WAIT, HALT}
- One sub-module, hazard_sat_cnt: saturating counter with enable and synchronous clear. Instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for exactly 1 cycle; stall_cycles=1.
- x0 immunity: ex_mem_read=1, ex_rd=0, id_rs2=0, id_uses_rs2=1 -> no stall; all writes=1.
- Branch plus load-use together: ex_branch_taken=1 and load_use=1 -> pc_write=1, if_id_flush=1, id_ex_flush=1; flush_count +1; no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_branch_taken=1 -> writes=0 for 3 cycles, then flush cycle; stall_cycles=3; state back to RUN.
- Timeout: mem_req=1, mem_ready=0 held for 16 cycles (MAX_MEM_WAIT=15) -> HALT, mem_timeout=1 sticky even after mem_ready=1. Reset -> RUN, mem_timeout=0, counters 0.
- Reset mid-wait: reset asserted in cycle 2 of a memory wait -> next cycle RUN, all outputs at reset values. Build with HAZARD_PERF_CNT_EN undefined -> counters read 0 throughout.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: register index width, the x0 index and the
// hazard sequencer state encoding.
package riscv_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    HALT
  } hz_state_e;

endpackage

// File: rtl/hazard_sat_cnt.sv
// Saturating up-counter with enable and synchronous clear (clear wins).
module hazard_sat_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes, memory-wait freeze and timeout halt. Macro: HAZARD_PERF_CNT_EN.
module if_id_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = riscv_pipe_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MAX_MEM_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  import riscv_pipe_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MAX_MEM_WAIT + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic load_use;
  logic mem_wait;

  assign load_use = ex_mem_read && (ex_rd != REG_ADDR_W'(X0)) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mem_wait = mem_req && !mem_ready;

  // Flushes override writes, so the write enables of flushed stages stay high.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    if (reset) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q != HALT && !mem_wait) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    mem_timeout_d = mem_timeout_q;
    if (reset) begin
      state_d       = RUN;
      wait_d        = '0;
      mem_timeout_d = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_wait) begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_d = RUN;
            wait_d  = '0;
          end else if (wait_q == WAIT_W'(MAX_MEM_WAIT)) begin
            state_d       = HALT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    wait_q        <= wait_d;
    mem_timeout_q <= mem_timeout_d;
  end

  assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .en  (!pc_write),
    .cnt (stall_cycles)
  );

  hazard_sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .en  (if_id_flush),
    .cnt (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Self-checking bench for if_id_hazard_ctrl: directed table, multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_if_id_hazard_ctrl;

  localparam int unsigned RW    = 5;
  localparam int unsigned CW    = 32;
  localparam int unsigned MAXW  = 15;
  localparam longint      CAP   = (64'd1 << CW) - 1;

  // Control bundle order: {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w}
  localparam logic [5:0] C_RST = 6'b001010;
  localparam logic [5:0] C_RUN = 6'b110101;
  localparam logic [5:0] C_FRZ = 6'b000000;
  localparam logic [5:0] C_BR  = 6'b111111;
  localparam logic [5:0] C_LU  = 6'b000111;

  typedef struct {
    logic          rst;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic          mr;
    logic [RW-1:0] rd;
    logic          br;
    logic          mq;
    logic          my;
    logic [5:0]    exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic          mem_req, mem_ready;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit     m_halted, m_waiting, m_timeout;
  int     m_waited;
  longint m_stall, m_flush;

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(
    .REG_ADDR_W   (RW),
    .CNT_W        (CW),
    .MAX_MEM_WAIT (MAXW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  function automatic vec_t mk(logic rst, logic [RW-1:0] rs1, logic u1,
                              logic [RW-1:0] rs2, logic u2, logic mr,
                              logic [RW-1:0] rd, logic br, logic mq,
                              logic my, logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.mr = mr; v.rd = rd; v.br = br; v.mq = mq; v.my = my; v.exp = exp;
    return v;
  endfunction

  function automatic longint cnt_exp(longint x);
`ifdef HAZARD_PERF_CNT_EN
    return x;
`else
    return 0;
`endif
  endfunction

  function automatic logic [5:0] model_ctrl(vec_t v);
    bit lu;
    if (v.rst) return C_RST;
    if (m_halted) return C_FRZ;
    lu = v.mr && (v.rd != 0) &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (v.mq && !v.my) return C_FRZ;
    if (v.br) return C_BR;
    if (lu) return C_LU;
    return C_RUN;
  endfunction

  task automatic model_step(vec_t v);
    logic [5:0] c;
    c = model_ctrl(v);
    if (v.rst) begin
      m_halted = 0; m_waiting = 0; m_timeout = 0; m_waited = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (!c[5] && m_stall < CAP) m_stall++;
      if (c[3] && m_flush < CAP) m_flush++;
      if (m_halted) begin
        // stays halted until reset
      end else if (m_waiting) begin
        if (v.my) begin
          m_waiting = 0;
        end else if (m_waited == MAXW) begin
          m_halted = 1; m_timeout = 1; m_waiting = 0;
        end else begin
          m_waited++;
        end
      end else if (v.mq && !v.my) begin
        m_waiting = 1; m_waited = 1;
      end
    end
  endtask

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 after the next one.
  task automatic apply(vec_t v, bit use_tbl, string nm);
    logic [5:0] e;
    reset = v.rst; id_rs1 = v.rs1; id_uses_rs1 = v.u1; id_rs2 = v.rs2;
    id_uses_rs2 = v.u2; ex_mem_read = v.mr; ex_rd = v.rd;
    ex_branch_taken = v.br; mem_req = v.mq; mem_ready = v.my;
    #2;
    e = use_tbl ? v.exp : model_ctrl(v);
    chk({nm, "_ctrl"}, longint'({pc_write, if_id_write, if_id_flush,
                                 id_ex_write, id_ex_flush, ex_mem_write}),
        longint'(e));
    chk({nm, "_tmo"}, longint'(mem_timeout), longint'(m_timeout));
    chk({nm, "_stall"}, longint'(stall_cycles), cnt_exp(m_stall));
    chk({nm, "_flush"}, longint'(flush_count), cnt_exp(m_flush));
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  task automatic do_reset(int n);
    for (int i = 0; i < n; i++)
      apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST), 1, "reset");
  endtask

  vec_t tbl[$];
  vec_t idle;

  initial begin
    idle = mk(0, 1, 1, 2, 1, 0, 0, 0, 0, 1, C_RUN);
    reset = 1; id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_uses_rs1 = 0;
    id_uses_rs2 = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 1;
    @(posedge clk); #1;
    model_step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RST));
    do_reset(2);

    // Single-cycle directed vectors from RUN
    tbl.push_back(mk(0, 5, 1, 0, 0, 1, 5, 0, 0, 1, C_LU));   // load-use rs1
    tbl.push_back(mk(0, 1, 0, 7, 1, 1, 7, 0, 0, 1, C_LU));   // load-use rs2
    tbl.push_back(mk(0, 3, 1, 0, 1, 1, 0, 0, 0, 1, C_RUN));  // x0 immunity
    tbl.push_back(mk(0, 9, 1, 9, 1, 0, 9, 0, 0, 1, C_RUN));  // not a load
    tbl.push_back(mk(0, 9, 0, 9, 0, 1, 9, 0, 0, 1, C_RUN));  // regs unused
    tbl.push_back(mk(0, 4, 1, 0, 0, 1, 4, 1, 0, 1, C_BR));   // branch + lu
    tbl.push_back(mk(0, 1, 1, 2, 1, 0, 3, 1, 1, 1, C_BR));   // branch, mem done
    tbl.push_back(mk(0, 4, 1, 0, 0, 1, 4, 1, 1, 0, C_FRZ));  // frozen branch
    tbl.push_back(mk(0, 4, 1, 0, 0, 1, 4, 0, 1, 0, C_FRZ));  // frozen lu
    tbl.push_back(mk(0, 4, 1, 0, 0, 1, 4, 0, 1, 1, C_LU));   // release + lu
    tbl.push_back(idle);
    foreach (tbl[i]) apply(tbl[i], 1, $sformatf("tbl%0d", i));

    // Load-use: exactly one bubble, then EX holds a NOP
    do_reset(1);
    apply(mk(0, 5, 1, 0, 0, 1, 5, 0, 0, 1, C_LU), 1, "lu_bubble");
    apply(mk(0, 5, 1, 0, 0, 0, 0, 0, 0, 1, C_RUN), 1, "lu_after");
    chk("lu_stall_total", longint'(stall_cycles), cnt_exp(1));

    // Branch with load-use: flush, no stall
    do_reset(1);
    apply(mk(0, 6, 1, 0, 0, 1, 6, 1, 0, 1, C_BR), 1, "br_lu");
    apply(idle, 1, "br_lu_after");
    chk("br_lu_flush", longint'(flush_count), cnt_exp(1));
    chk("br_lu_stall", longint'(stall_cycles), cnt_exp(0));

    // Memory wait 3 cycles with branch held in EX, then release
    do_reset(1);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 1, 1, 2, 1, 0, 3, 1, 1, 0, C_FRZ), 1, "mw_freeze");
    apply(mk(0, 1, 1, 2, 1, 0, 3, 1, 1, 1, C_BR), 1, "mw_release");
    apply(idle, 1, "mw_after");
    chk("mw_stall_total", longint'(stall_cycles), cnt_exp(3));
    chk("mw_flush_total", longint'(flush_count), cnt_exp(1));
    chk("mw_back_run", longint'(mem_timeout), 0);

    // Timeout: 16 wait cycles -> sticky halt
    do_reset(1);
    for (int i = 0; i < 16; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ), 1, "to_wait");
    chk("to_flag", longint'(mem_timeout), 1);
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_FRZ), 1, "to_halt");
    chk("to_sticky", longint'(mem_timeout), 1);
    chk("to_stall_total", longint'(stall_cycles), cnt_exp(19));
    do_reset(1);
    chk("to_clr_flag", longint'(mem_timeout), 0);
    chk("to_clr_stall", longint'(stall_cycles), 0);
    apply(idle, 1, "to_after_reset");

    // Reset in the second cycle of a memory wait
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ), 1, "rmw_wait1");
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST), 1, "rmw_reset");
    apply(idle, 1, "rmw_run");
    chk("rmw_stall", longint'(stall_cycles), 0);
    // A fresh wait must take the full 16 cycles to time out
    for (int i = 0; i < 15; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ), 1, "rmw_rewait");
    chk("rmw_no_early_tmo", longint'(mem_timeout), 0);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_RUN), 1, "rmw_release");

    // Randomized traffic against the model
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.rst = ($urandom_range(0, 59) == 0);
      v.rs1 = RW'($urandom_range(0, 3));
      v.rs2 = RW'($urandom_range(0, 3));
      v.rd  = RW'($urandom_range(0, 3));
      v.u1  = 1'($urandom);
      v.u2  = 1'($urandom);
      v.mr  = 1'($urandom);
      v.br  = ($urandom_range(0, 4) == 0);
      v.mq  = ($urandom_range(0, 2) == 0);
      v.my  = v.mq ? ($urandom_range(0, 9) < 3) : 1'b1;
      v.exp = '0;
      apply(v, 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
